// File: rtl/conn_table.sv
// Connection table for 4-beat 5-tuples: open addressing with linear probing,
// tombstone deletion, one slot examined per clock and a single-entry result register.
module conn_table #(
  parameter int HASH_LEN  = 10,
  parameter int MAX_PROBE = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tuple_valid_i,
  input  logic [31:0]       tuple_data_i,
  input  logic [1:0]        tuple_op_i,
  output logic              tuple_ready_o,
  output logic              conn_valid_o,
  output logic [31:0]       conn_data_o,
  input  logic              conn_ready_i,
  output logic [HASH_LEN:0] entries_o
);
  localparam int DEPTH = 1 << HASH_LEN;

  typedef enum logic [1:0] {S_EMPTY = 2'd0, S_LIVE = 2'd1, S_TOMB = 2'd2} slot_t;
  typedef enum logic [1:0] {OP_INS = 2'd0, OP_LOOK = 2'd1, OP_DEL = 2'd2} op_t;
  typedef enum logic {E_IDLE = 1'b0, E_PROBE = 1'b1} eng_t;

  localparam logic [HASH_LEN:0]   CNT_LAST = (HASH_LEN+1)'(MAX_PROBE - 1);
  localparam logic [HASH_LEN:0]   CNT_ONE  = (HASH_LEN+1)'(1);
  localparam logic [HASH_LEN-1:0] IDX_ONE  = (HASH_LEN)'(1);

  logic                ready_r, asm_full_r, tomb_seen_r, out_valid_r;
  logic [1:0]          beat_r;
  op_t                 asm_op_r, op_r;
  eng_t                eng_r;
  logic [103:0]        asm_key_r, key_r;
  logic [HASH_LEN-1:0] idx_r, tomb_idx_r;
  logic [HASH_LEN:0]   cnt_r, entries_r;
  logic [31:0]         out_data_r;
  logic [DEPTH-1:0]    live_r, tomb_r;
  logic [103:0]        slot_key_r [DEPTH];

  logic                accept_s, take_s, asm_full_nxt_s, match_s, done_s, have_tomb_s;
  logic                set_live_s, set_tomb_s, inc_s, dec_s;
  slot_t               cur_st_s;
  op_t                 in_op_s;
  logic [HASH_LEN-1:0] hash_s, first_tomb_s, wr_idx_s;
  logic [31:0]         res_s;

  assign tuple_ready_o = ready_r;
  assign conn_valid_o  = out_valid_r;
  assign conn_data_o   = out_data_r;
  assign entries_o     = entries_r;

  assign accept_s = tuple_valid_i & ready_r;
  assign take_s   = asm_full_r & (eng_r == E_IDLE) & (~out_valid_r | conn_ready_i);
  assign hash_s   = asm_key_r[72 +: HASH_LEN] ^ asm_key_r[40 +: HASH_LEN]
                  ^ (HASH_LEN)'(asm_key_r[39:24]) ^ (HASH_LEN)'(asm_key_r[23:8])
                  ^ (HASH_LEN)'(asm_key_r[7:0]);

  assign match_s      = (cur_st_s == S_LIVE) && (slot_key_r[idx_r] == key_r);
  assign done_s       = (eng_r == E_PROBE) && (match_s || cur_st_s == S_EMPTY || cnt_r == CNT_LAST);
  assign have_tomb_s  = tomb_seen_r | (cur_st_s == S_TOMB);
  assign first_tomb_s = tomb_seen_r ? tomb_idx_r : idx_r;

  // Decode the opcode (11 behaves as lookup-only) and the state of the probed slot.
  always_comb begin
    in_op_s  = OP_LOOK;
    cur_st_s = S_EMPTY;
    if (tuple_op_i == 2'b11) in_op_s = OP_LOOK;
    else                     in_op_s = op_t'(tuple_op_i);
    if (live_r[idx_r])       cur_st_s = S_LIVE;
    else if (tomb_r[idx_r])  cur_st_s = S_TOMB;
    else                     cur_st_s = S_EMPTY;
  end

  // Assembly buffer occupancy: filled by beat 3, emptied when the probe engine takes it.
  always_comb begin
    asm_full_nxt_s = asm_full_r;
    if (accept_s && beat_r == 2'd3) asm_full_nxt_s = 1'b1;
    else if (take_s)                asm_full_nxt_s = 1'b0;
    else                            asm_full_nxt_s = asm_full_r;
  end

  // Result word and table update for the slot on which the probe stops.
  always_comb begin
    res_s      = 32'd0;
    wr_idx_s   = idx_r;
    set_live_s = 1'b0;
    set_tomb_s = 1'b0;
    inc_s      = 1'b0;
    dec_s      = 1'b0;
    if (done_s) begin
      if (match_s) begin
        res_s[HASH_LEN-1:0] = idx_r;
        if (op_r == OP_DEL) begin
          res_s[28]  = 1'b1;
          set_tomb_s = 1'b1;
          dec_s      = 1'b1;
        end else begin
          res_s[30] = 1'b1;
        end
      end else if (op_r == OP_INS) begin
        // A tombstone passed earlier is reused in preference to the stopping empty slot.
        if (have_tomb_s || cur_st_s == S_EMPTY) begin
          wr_idx_s            = have_tomb_s ? first_tomb_s : idx_r;
          res_s[29]           = 1'b1;
          res_s[HASH_LEN-1:0] = wr_idx_s;
          set_live_s          = 1'b1;
          inc_s               = 1'b1;
        end else begin
          res_s[31] = 1'b1;
        end
      end else begin
        res_s = 32'd0;
      end
    end else begin
      res_s = 32'd0;
    end
  end

  // Slot states; contents are left untouched by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live_r <= '0;
      tomb_r <= '0;
    end else if (set_live_s) begin
      live_r[wr_idx_s] <= 1'b1;
      tomb_r[wr_idx_s] <= 1'b0;
    end else if (set_tomb_s) begin
      live_r[wr_idx_s] <= 1'b0;
      tomb_r[wr_idx_s] <= 1'b1;
    end
  end

  // Slot tuple storage.
  always_ff @(posedge clk) begin
    if (set_live_s) slot_key_r[wr_idx_s] <= key_r;
  end

  // Beat assembly, probe engine FSM, result register and live-entry count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_r     <= 1'b0;
      beat_r      <= 2'd0;
      asm_full_r  <= 1'b0;
      asm_op_r    <= OP_INS;
      asm_key_r   <= 104'd0;
      eng_r       <= E_IDLE;
      op_r        <= OP_INS;
      key_r       <= 104'd0;
      idx_r       <= '0;
      cnt_r       <= '0;
      tomb_seen_r <= 1'b0;
      tomb_idx_r  <= '0;
      out_valid_r <= 1'b0;
      out_data_r  <= 32'd0;
      entries_r   <= '0;
    end else begin
      asm_full_r <= asm_full_nxt_s;
      ready_r    <= ~asm_full_nxt_s;
      if (accept_s) begin
        beat_r <= beat_r + 2'd1;
        case (beat_r)
          2'd0: begin
            asm_key_r[103:72] <= tuple_data_i;
            asm_op_r          <= in_op_s;
          end
          2'd1: asm_key_r[71:40] <= tuple_data_i;
          2'd2: begin
            asm_key_r[39:24] <= tuple_data_i[15:0];
            asm_key_r[23:8]  <= tuple_data_i[31:16];
          end
          2'd3: asm_key_r[7:0] <= tuple_data_i[7:0];
          default: beat_r <= 2'd0;
        endcase
      end

      case (eng_r)
        E_IDLE: begin
          if (take_s) begin
            eng_r       <= E_PROBE;
            idx_r       <= hash_s;
            cnt_r       <= '0;
            tomb_seen_r <= 1'b0;
            tomb_idx_r  <= '0;
            op_r        <= asm_op_r;
            key_r       <= asm_key_r;
          end
        end
        E_PROBE: begin
          if (done_s) begin
            eng_r <= E_IDLE;
          end else begin
            idx_r <= idx_r + IDX_ONE;
            cnt_r <= cnt_r + CNT_ONE;
            if (cur_st_s == S_TOMB && !tomb_seen_r) begin
              tomb_seen_r <= 1'b1;
              tomb_idx_r  <= idx_r;
            end
          end
        end
        default: eng_r <= E_IDLE;
      endcase

      if (out_valid_r && conn_ready_i) out_valid_r <= 1'b0;
      if (done_s) begin
        out_valid_r <= 1'b1;
        out_data_r  <= res_s;
      end
      if (inc_s)      entries_r <= entries_r + CNT_ONE;
      else if (dec_s) entries_r <= entries_r - CNT_ONE;
    end
  end
endmodule

// File: tb/tb_conn_table.sv
// Directed scoreboard bench for conn_table (HASH_LEN=10, MAX_PROBE=4): the driver
// queues hand-computed results, a negedge monitor pops and compares them.
module tb_conn_table;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tuple_valid_i = 1'b0;
  logic [31:0] tuple_data_i = 32'd0;
  logic [1:0]  tuple_op_i = 2'd0;
  logic        tuple_ready_o;
  logic        conn_valid_o;
  logic [31:0] conn_data_o;
  logic        conn_ready_i = 1'b1;
  logic [10:0] entries_o;

  conn_table #(.HASH_LEN(10), .MAX_PROBE(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .tuple_valid_i(tuple_valid_i), .tuple_data_i(tuple_data_i), .tuple_op_i(tuple_op_i),
    .tuple_ready_o(tuple_ready_o),
    .conn_valid_o(conn_valid_o), .conn_data_o(conn_data_o), .conn_ready_i(conn_ready_i),
    .entries_o(entries_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [10:0] ent;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  logic        prev_hold = 1'b0;
  logic [31:0] held = 32'd0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Monitor: pops one expectation per accepted result; checks latency and hold stability.
  always @(negedge clk) begin
    if (rst_n && conn_valid_o) begin
      if (prev_hold) check("hold_stable", conn_data_o, held);
      else if (sb.size() > 0 && sb[0].cyc >= 0) check("latency", cyc, sb[0].cyc);
      if (conn_ready_i) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_result: got 0x%08h, expected none", conn_data_o);
        end else begin
          mon_e = sb.pop_front();
          check("result", conn_data_o, mon_e.data);
          check("entries", {21'd0, entries_o}, {21'd0, mon_e.ent});
        end
        prev_hold <= 1'b0;
      end else begin
        prev_hold <= 1'b1;
        held      <= conn_data_o;
      end
    end else begin
      prev_hold <= 1'b0;
    end
  end

  task automatic put_beat(input logic [31:0] d, input logic [1:0] op);
    int   guard = 0;
    logic rdy;
    tuple_valid_i = 1'b1;
    tuple_data_i  = d;
    tuple_op_i    = op;
    forever begin
      @(negedge clk);
      rdy = tuple_ready_o;
      @(posedge clk);
      if (rdy) break;
      guard++;
      if (guard > 200) begin
        n_cmp++;
        n_bad++;
        $display("FAIL beat_timeout: got ready=0, expected ready=1");
        break;
      end
    end
    #1;
  endtask

  task automatic wait_idle();
    int g = 0;
    while ((sb.size() != 0 || conn_valid_o) && g < 300) begin
      @(posedge clk);
      #1;
      g++;
    end
    if (g >= 300) begin
      n_cmp++;
      n_bad++;
      $display("FAIL idle_timeout: got %0d pending, expected 0", sb.size());
      sb.delete();
    end
  endtask

  // k > 0: result expected exactly at T+2+k; k <= 0: latency not checked.
  task automatic send(input logic [1:0] op, input logic [31:0] b0, input logic [31:0] b1,
                      input logic [31:0] b2, input logic [31:0] b3,
                      input logic [31:0] exp, input int ent, input int k, input bit idle);
    exp_t e;
    if (idle) wait_idle();
    put_beat(b0, op);
    put_beat(b1, op);
    put_beat(b2, op);
    put_beat(b3, op);
    tuple_valid_i = 1'b0;
    e.data = exp;
    e.ent  = ent[10:0];
    e.cyc  = (k > 0) ? (cyc + 1 + k) : -1;
    sb.push_back(e);
  endtask

  localparam logic [31:0] DIP = 32'h0A000002;
  localparam logic [31:0] PRT = 32'h00500400;
  localparam logic [31:0] PRO = 32'h00000006;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    check("rst_valid", {31'd0, conn_valid_o}, 32'd0);
    check("rst_data", conn_data_o, 32'd0);
    check("rst_entries", {21'd0, entries_o}, 32'd0);
    check("rst_ready", {31'd0, tuple_ready_o}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_release", {31'd0, tuple_ready_o}, 32'd1);

    // insert, repeat, collision, then fill the 0x055 cluster to exhaustion
    send(2'b00, 32'h0A000001, DIP, PRT, PRO, 32'h20000055, 1, 1, 1'b1);
    send(2'b00, 32'h0A000001, DIP, PRT, PRO, 32'h40000055, 1, 1, 1'b1);
    send(2'b00, 32'h0A000401, DIP, PRT, PRO, 32'h20000056, 2, 2, 1'b1);
    send(2'b00, 32'h0A000801, DIP, PRT, PRO, 32'h20000057, 3, 3, 1'b1);
    send(2'b00, 32'h0A000C01, DIP, PRT, PRO, 32'h20000058, 4, 4, 1'b1);
    send(2'b00, 32'h0A001001, DIP, PRT, PRO, 32'h80000000, 4, 4, 1'b1);
    // delete and tombstone reuse
    send(2'b10, 32'h0A000001, DIP, PRT, PRO, 32'h10000055, 3, 1, 1'b1);
    send(2'b01, 32'h0A000401, DIP, PRT, PRO, 32'h40000056, 3, 2, 1'b1);
    send(2'b00, 32'h0A000001, DIP, PRT, PRO, 32'h20000055, 4, 4, 1'b1);
    send(2'b11, 32'h0A000801, DIP, PRT, PRO, 32'h40000057, 4, 3, 1'b1);
    // misses leave the table alone
    send(2'b01, 32'h12345678, 32'd0, 32'd0, 32'd0, 32'h00000000, 4, 1, 1'b1);
    send(2'b10, 32'h12345678, 32'd0, 32'd0, 32'd0, 32'h00000000, 4, 1, 1'b1);
    // wrap-around from 0x3FF to 0x000
    send(2'b00, 32'h000003FF, 32'd0, 32'd0, 32'd0, 32'h200003FF, 5, 1, 1'b1);
    send(2'b00, 32'h000007FF, 32'd0, 32'd0, 32'd0, 32'h20000000, 6, 2, 1'b1);

    // backpressure: result held while the next tuple waits assembled
    wait_idle();
    conn_ready_i = 1'b0;
    send(2'b01, 32'h0A000001, DIP, PRT, PRO, 32'h40000055, 6, 1, 1'b1);
    begin
      int g = 0;
      while (!conn_valid_o && g < 50) begin
        @(posedge clk);
        #1;
        g++;
      end
      check("bp_valid_seen", {31'd0, conn_valid_o}, 32'd1);
    end
    send(2'b01, 32'h0A000401, DIP, PRT, PRO, 32'h40000056, 6, 0, 1'b0);
    @(negedge clk);
    check("bp_ready_low", {31'd0, tuple_ready_o}, 32'd0);
    repeat (10) @(negedge clk);
    check("bp_ready_still_low", {31'd0, tuple_ready_o}, 32'd0);
    @(posedge clk);
    #1;
    conn_ready_i = 1'b1;
    wait_idle();

    // reset in the middle of beat 2
    put_beat(32'h0A000C01, 2'b00);
    put_beat(DIP, 2'b00);
    tuple_data_i = PRT;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {31'd0, conn_valid_o}, 32'd0);
    check("mid_rst_data", conn_data_o, 32'd0);
    check("mid_rst_entries", {21'd0, entries_o}, 32'd0);
    check("mid_rst_ready", {31'd0, tuple_ready_o}, 32'd0);
    tuple_valid_i = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_rst2", {31'd0, tuple_ready_o}, 32'd1);
    send(2'b01, 32'h0A000001, DIP, PRT, PRO, 32'h00000000, 0, 1, 1'b1);
    send(2'b00, 32'h0A000001, DIP, PRT, PRO, 32'h20000055, 1, 1, 1'b1);
    wait_idle();
    check("drained", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/conn_table.md
CONN_TABLE -- requirements
Module: conn_table

Interface
REQ-001 SHALL have parameter HASH_LEN, default 10, meaning index width; table depth 2^HASH_LEN; legal range 4..28.
REQ-002 SHALL have parameter MAX_PROBE, default 16, meaning maximum slots examined per request; legal range 1..2^HASH_LEN.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port tuple_valid_i  input  1  input word valid.
REQ-006 SHALL have port tuple_data_i  input  32  input word.
REQ-007 SHALL have port tuple_op_i  input  2  operation code, sampled on beat 0 only: 00 insert-or-lookup, 01 lookup-only, 10 delete, 11 treated as 01.
REQ-008 SHALL have port tuple_ready_o  output  1  input word accepted when high together with tuple_valid_i.
REQ-009 SHALL have port conn_valid_o  output  1  result valid.
REQ-010 SHALL have port conn_data_o  output  32  result word: [31] fail, [30] hit, [29] inserted, [28] deleted, [HASH_LEN-1:0] id, all other bits 0.
REQ-011 SHALL have port conn_ready_i  input  1  result accepted when high together with conn_valid_o.
REQ-012 SHALL have port entries_o  output  HASH_LEN+1  count of live entries.

Function
REQ-013 SHALL assemble each request from 4 accepted beats: beat 0 srcip, beat 1 dstip, beat 2 srcport=[15:0] and dstport=[31:16], beat 3 protocol=[7:0]; beat 3 [31:8] ignored.
REQ-014 SHALL hold tuple_ready_o low while an assembled tuple awaits the probe engine; beats for the next tuple may be accepted while a probe is in progress.
REQ-015 SHALL compute hash = low HASH_LEN bits of (srcip ^ dstip ^ srcport ^ dstport ^ protocol), zero-extended operands, registered one cycle after beat 3 acceptance.
REQ-016 SHALL keep per slot a 104-bit tuple plus state EMPTY, LIVE or TOMB.
REQ-017 SHALL probe one slot per cycle starting at hash, index incremented modulo 2^HASH_LEN, wrapping from 2^HASH_LEN-1 to 0.
REQ-018 SHALL stop probing on a LIVE slot whose tuple matches, on an EMPTY slot, or after MAX_PROBE slots; TOMB slots never stop the probe.
REQ-019 SHALL, on match: insert/lookup -> hit=1, id=slot; delete -> slot becomes TOMB, deleted=1, id=slot, entries_o decrements.
REQ-020 SHALL, on insert with no match: write the tuple into the first TOMB seen, else the stopping EMPTY slot; set LIVE, inserted=1, id=slot, entries_o increments.
REQ-021 SHALL, on insert with no match and no TOMB/EMPTY within MAX_PROBE slots, leave the table unchanged and return fail=1, id=0.
REQ-022 SHALL, on lookup-only or delete with no match, return all-zero result word and leave the table unchanged.
REQ-023 SHALL present conn_valid_o in cycle T+2+k, where T = beat 3 acceptance cycle and k = number of slots examined (minimum 1, so minimum T+3).
REQ-024 SHALL hold conn_valid_o and conn_data_o stable until conn_ready_i is high; the probe engine accepts no new tuple while a result is unaccepted, unless that result is accepted in the same cycle.
REQ-025 SHALL process requests strictly in arrival order, one in the probe engine at a time, with each request observing all table updates of earlier requests.
REQ-026 SHALL never exceed 2^HASH_LEN on entries_o.

Reset
REQ-027 SHALL, on rst_n low, immediately set every slot to EMPTY, the beat counter to beat 0, and discard any partial, assembled, in-probe or unaccepted request.
REQ-028 SHALL, during reset, drive conn_valid_o=0, conn_data_o=0, entries_o=0 and tuple_ready_o=0; tuple_ready_o=1 from the first clock edge after release.
REQ-029 SHALL clear only slot state on reset; slot tuple contents are don't-care.

Verification (HASH_LEN=10, MAX_PROBE=4)
REQ-030 SHALL verify insert: op 00, beats 0x0A000001, 0x0A000002, 0x00500400, 0x00000006 -> conn_data_o=0x20000055 at T+3, entries_o=1; repeat the same tuple -> 0x40000055.
REQ-031 SHALL verify collision: op 00, srcip 0x0A000401 with the other beats as REQ-030 -> 0x20000056 at T+4.
REQ-032 SHALL verify wrap-around: fill slot 0x3FF, then insert a tuple hashing to 0x3FF -> id 0x000.
REQ-033 SHALL verify exhaustion: 5 distinct tuples hashing to 0x055 -> first four return ids 0x055..0x058, fifth returns 0x80000000 with entries_o unchanged.
REQ-034 SHALL verify delete and tombstone: delete the REQ-030 tuple -> 0x10000055; lookup-only of the REQ-031 tuple -> 0x40000056; re-insert of the REQ-030 tuple -> 0x20000055.
REQ-035 SHALL verify backpressure and reset: hold conn_ready_i=0 for 10 cycles with the output stable and tuple_ready_o low after the next tuple is assembled; assert rst_n low mid-beat-2 -> outputs zero, and after release the first lookup returns 0x00000000.
